motion_highlight: RTL and testbench
===================================

// Module: motion_highlight
// PURPOSE
//  Final stage of motion_detect_top. Pops one grayscale background pixel, one grayscale
//  frame pixel and one original RGB frame pixel per transaction, all from upstream FIFOs.
//  Thresholds |fr - bg| and pushes either HIGHLIGHT_COLOR or the original pixel to the
//  output FIFO. Also counts pixels per frame and reports the per-frame motion pixel count.
// PARAMETERS
//  WIDTH            768         image width in pixels
//  HEIGHT           576         image height in pixels
//  THRESHOLD        8'd50       motion when |fr-bg| > THRESHOLD (strict)
//  HIGHLIGHT_COLOR  24'h0000FF  replacement pixel, BMP byte order {B,G,R} (red)
// PORTS
//  clock         in   1   system clock, all logic on posedge
//  reset         in   1   asynchronous, active-low reset
//  bg_dout       in   8   background gray pixel, FWFT (valid while !bg_empty)
//  bg_empty      in   1   background FIFO empty
//  bg_rd_en      out  1   pop background FIFO
//  fr_dout       in   8   frame gray pixel, FWFT
//  fr_empty      in   1   frame gray FIFO empty
//  fr_rd_en      out  1   pop frame gray FIFO
//  hl_dout       in   24  original frame RGB pixel, FWFT
//  hl_empty      in   1   highlight-frame FIFO empty
//  hl_rd_en      out  1   pop highlight-frame FIFO
//  out_din       out  24  result pixel
//  out_full      in   1   output FIFO full
//  out_wr_en     out  1   push result pixel
//  frame_done    out  1   1-cycle pulse on the push of the last pixel of a frame
//  motion_count  out  19  highlighted-pixel count of the last completed frame
// BEHAVIOUR
//  - Reset (reset==0, async): all rd_en/out_wr_en=0, out_din=0, frame_done=0,
//    motion_count=0, valid bits and pixel counter cleared. Mid-frame reset drops
//    in-flight pixels; no FIFO pop/push occurs while reset is low.
//  - Pipeline: S1 registers {absdiff(8b), rgb}; S2 registers {out pixel}. valid1/valid2.
//    adv2 = !valid2 | !out_full; adv1 = !valid1 | adv2.
//    take = !bg_empty & !fr_empty & !hl_empty & adv1.
//  - bg_rd_en = fr_rd_en = hl_rd_en = take (combinational). The three FIFOs always
//    pop together; never pop one alone.
//  - absdiff: zero-extend to 9b, subtract, take magnitude; result is 8b, no overflow.
//  - S2 selects HIGHLIGHT_COLOR if absdiff > THRESHOLD, else rgb unchanged.
//  - out_wr_en = valid2 & !out_full; out_din = S2 pixel. Input-to-output latency is
//    2 cycles with no backpressure. Sustained throughput is 1 pixel/cycle.
//  - Backpressure: while out_full=1, S2 holds. S1 holds if S2 is valid. No pops once
//    both stages are full. No pixel is lost or duplicated.
//  - Counters advance only on out_wr_en. pix_cnt counts 0..WIDTH*HEIGHT-1.
//    mot_acc increments for each highlighted push.
//  - On the push with pix_cnt==WIDTH*HEIGHT-1: frame_done=1 for that cycle,
//    motion_count <= mot_acc + (this pixel highlighted), and pix_cnt and mot_acc wrap to 0.
//  - Empty input: if any input FIFO is empty, no pop occurs and the pipeline drains normally.
// STRUCTURE
//  - motion_detect_pkg: PIXEL_W=24, GRAY_W=8, typedef rgb_t, typedef gray_t,
//    function abs_diff(gray_t, gray_t).
//  - Single module, no sub-modules. FIFOs are instantiated in motion_detect_top.
// TESTING
//  1. Reset, then bg=10, fr=60, hl=24'h112233 -> out 24'h112233 (diff 50, not >50), 2-cycle latency.
//  2. bg=200, fr=10, hl=24'hABCDEF -> out 24'h0000FF (diff 190). Checks abs order.
//  3. Hold out_full=1 for 5 cycles during a 10-pixel stream -> at most 2 pops beyond the
//     last push, all 10 outputs in order, no duplicates.
//  4. Starve only hl_empty=1 -> all three rd_en stay 0, and bg/fr are not popped.
//  5. Small WIDTH=4, HEIGHT=2, 3 motion pixels -> frame_done pulses once on the 8th push,
//     motion_count=3. The next frame restarts the count at 0.
//  6. Assert reset mid-frame with valid1=valid2=1 -> out_wr_en=0 at once; after release,
//     a new full frame gives the correct frame_done and motion_count.

Source files
------------

// File: rtl/motion_detect_pkg.sv
// Shared types and helpers for the motion-detect pipeline.
// This package holds the pixel types, the stage-1 payload and the absolute-difference helper.
package motion_detect_pkg;

    localparam int unsigned PIXEL_W = 24;
    localparam int unsigned GRAY_W  = 8;
    localparam int unsigned DIFF_W  = GRAY_W + 1;
    localparam int unsigned CNT_W   = 19;

    typedef logic [PIXEL_W-1:0] rgb_t;
    typedef logic [GRAY_W-1:0]  gray_t;
    typedef logic [DIFF_W-1:0]  diff_t;
    typedef logic [CNT_W-1:0]   cnt_t;

    typedef struct packed {
        gray_t diff;
        rgb_t  rgb;
    } s1_t;

    // Magnitude of a - b. The 9-bit signed intermediate cannot overflow.
    function automatic gray_t abs_diff(input gray_t a, input gray_t b);
        diff_t d;
        d = diff_t'(a) - diff_t'(b);
        return d[GRAY_W] ? gray_t'(~d + diff_t'(1)) : gray_t'(d);
    endfunction

endpackage

// File: rtl/motion_highlight.sv
// Final motion-detect stage: thresholds |frame - background| and pushes either the highlight
// colour or the original RGB pixel. It also reports the number of motion pixels in each frame.
module motion_highlight
    import motion_detect_pkg::*;
#(
    parameter int unsigned WIDTH           = 768,
    parameter int unsigned HEIGHT          = 576,
    parameter gray_t       THRESHOLD       = 8'd50,
    parameter rgb_t        HIGHLIGHT_COLOR = 24'h0000FF
) (
    input  logic             clock,
    input  logic             reset,
    input  gray_t            bg_dout,
    input  logic             bg_empty,
    output logic             bg_rd_en,
    input  gray_t            fr_dout,
    input  logic             fr_empty,
    output logic             fr_rd_en,
    input  rgb_t             hl_dout,
    input  logic             hl_empty,
    output logic             hl_rd_en,
    output rgb_t             out_din,
    input  logic             out_full,
    output logic             out_wr_en,
    output logic             frame_done,
    output logic [CNT_W-1:0] motion_count
);

    localparam int unsigned FRAME_PIX = WIDTH * HEIGHT;
    localparam cnt_t        LAST_PIX  = CNT_W'(FRAME_PIX - 1);

    s1_t  r_s1;
    logic r_valid1;
    rgb_t r_pix2;
    logic r_hl2;
    logic r_valid2;
    cnt_t r_pix_cnt;
    cnt_t r_mot_acc;
    cnt_t r_motion_count;

    logic w_adv1;
    logic w_adv2;
    logic w_take;
    logic w_push;
    logic w_last;
    logic w_hl1;

    // Handshake: the three input FIFOs are always popped together, and never while in reset.
    always_comb begin
        w_adv2 = !r_valid2 || !out_full;
        w_adv1 = !r_valid1 || w_adv2;
        w_take = reset && !bg_empty && !fr_empty && !hl_empty && w_adv1;
        w_push = r_valid2 && !out_full;
        w_last = (r_pix_cnt == LAST_PIX);
        w_hl1  = (r_s1.diff > THRESHOLD);
    end

    assign bg_rd_en     = w_take;
    assign fr_rd_en     = w_take;
    assign hl_rd_en     = w_take;
    assign out_wr_en    = w_push;
    assign out_din      = r_pix2;
    assign frame_done   = w_push && w_last;
    assign motion_count = r_motion_count;

    // Stage 1: difference magnitude alongside the original pixel.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_valid1 <= 1'b0;
            r_s1     <= '0;
        end else if (w_adv1) begin
            r_valid1 <= w_take;
            if (w_take) begin
                r_s1.diff <= abs_diff(fr_dout, bg_dout);
                r_s1.rgb  <= hl_dout;
            end
        end
    end

    // Stage 2: choose the output pixel and remember whether it was highlighted.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_valid2 <= 1'b0;
            r_pix2   <= '0;
            r_hl2    <= 1'b0;
        end else if (w_adv2) begin
            r_valid2 <= r_valid1;
            if (r_valid1) begin
                r_pix2 <= w_hl1 ? HIGHLIGHT_COLOR : r_s1.rgb;
                r_hl2  <= w_hl1;
            end
        end
    end

    // Frame counters advance only on an actual push; they wrap on the last pixel of a frame.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pix_cnt      <= '0;
            r_mot_acc      <= '0;
            r_motion_count <= '0;
        end else if (w_push) begin
            if (w_last) begin
                r_pix_cnt      <= '0;
                r_mot_acc      <= '0;
                r_motion_count <= r_mot_acc + CNT_W'(r_hl2);
            end else begin
                r_pix_cnt <= r_pix_cnt + CNT_W'(1);
                r_mot_acc <= r_mot_acc + CNT_W'(r_hl2);
            end
        end
    end

endmodule

// File: tb/tb_motion_highlight.sv
// Directed self-checking bench for motion_highlight, configured with a 4x2 frame.
module tb_motion_highlight;
    import motion_detect_pkg::*;

    logic             clock;
    logic             reset;
    gray_t            bg_dout;
    logic             bg_empty;
    logic             bg_rd_en;
    gray_t            fr_dout;
    logic             fr_empty;
    logic             fr_rd_en;
    rgb_t             hl_dout;
    logic             hl_empty;
    logic             hl_rd_en;
    rgb_t             out_din;
    logic             out_full;
    logic             out_wr_en;
    logic             frame_done;
    logic [CNT_W-1:0] motion_count;

    motion_highlight #(.WIDTH(4), .HEIGHT(2)) dut (
        .clock(clock), .reset(reset),
        .bg_dout(bg_dout), .bg_empty(bg_empty), .bg_rd_en(bg_rd_en),
        .fr_dout(fr_dout), .fr_empty(fr_empty), .fr_rd_en(fr_rd_en),
        .hl_dout(hl_dout), .hl_empty(hl_empty), .hl_rd_en(hl_rd_en),
        .out_din(out_din), .out_full(out_full), .out_wr_en(out_wr_en),
        .frame_done(frame_done), .motion_count(motion_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int   errors = 0;
    int   checks = 0;
    rgb_t q[$];
    int   pop_n   = 0;
    int   push_n  = 0;
    int   fd_n    = 0;
    int   fd_idx  = -1;
    int   split_n = 0;

    // Passive monitor: logs pushes, pops and frame_done pulses mid-cycle.
    always @(negedge clock) begin
        if (out_wr_en) begin
            q.push_back(out_din);
            if (frame_done) fd_idx = push_n;
            push_n = push_n + 1;
        end
        if (frame_done) fd_n = fd_n + 1;
        if (bg_rd_en) pop_n = pop_n + 1;
        if ((bg_rd_en != fr_rd_en) || (bg_rd_en != hl_rd_en)) split_n = split_n + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bg_empty = 1'b1;
        fr_empty = 1'b1;
        hl_empty = 1'b1;
    endtask

    // Present one pixel on all three FIFOs and hold it until it is popped.
    task automatic push_px(input gray_t b, input gray_t f, input rgb_t h);
        logic got;
        bg_dout = b; fr_dout = f; hl_dout = h;
        bg_empty = 1'b0; fr_empty = 1'b0; hl_empty = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clock);
            got = bg_rd_en;
        end
        if (!got) chk("pop_timeout", 32'(got), 32'd1);
        @(posedge clock);
        #1;
        idle();
    endtask

    // Pixels with bit i of the mask set differ by 200 and get highlighted; the rest differ by 10.
    task automatic send_mask(input int n, input logic [7:0] mask, input rgb_t base);
        for (int i = 0; i < n; i++) begin
            if (mask[i]) push_px(8'd0, 8'd200, base | 24'(i));
            else         push_px(8'd30, 8'd40, base | 24'(i));
        end
    endtask

    gray_t bg5 [8] = '{8'd0, 8'd10,  8'd100, 8'd200, 8'd20, 8'd0,  8'd0,   8'd77};
    gray_t fr5 [8] = '{8'd0, 8'd61,  8'd150, 8'd0,   8'd30, 8'd49, 8'd255, 8'd77};
    logic  mot5 [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    int qb;
    int pb;
    int sb;
    int fb;
    int pf;

    initial begin
        // Reset: outputs quiet even with all FIFOs non-empty.
        reset = 1'b0; out_full = 1'b0;
        bg_dout = 8'd10; fr_dout = 8'd60; hl_dout = 24'h112233;
        bg_empty = 1'b0; fr_empty = 1'b0; hl_empty = 1'b0;
        wait_cyc(2);
        chk("rst_rd_en", 32'(bg_rd_en | fr_rd_en | hl_rd_en), 32'd0);
        chk("rst_wr_en", 32'(out_wr_en), 32'd0);
        chk("rst_out_din", 32'(out_din), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_motion_count", 32'(motion_count), 32'd0);
        chk("rst_no_pop", 32'(pop_n), 32'd0);

        // Test 1: diff of exactly 50 passes through; 2-cycle latency.
        reset = 1'b1;
        #1;
        chk("t1_take", 32'(bg_rd_en), 32'd1);
        @(posedge clock); #1;
        idle();
        chk("t1_lat1_wr", 32'(out_wr_en), 32'd0);
        @(posedge clock); #1;
        chk("t1_lat2_wr", 32'(out_wr_en), 32'd1);
        chk("t1_out", 32'(out_din), 32'h112233);
        @(posedge clock); #1;
        chk("t1_after_wr", 32'(out_wr_en), 32'd0);
        chk("t1_pops", 32'(pop_n), 32'd1);

        // Test 2: background brighter than frame, diff 190.
        qb = q.size();
        push_px(8'd200, 8'd10, 24'hABCDEF);
        wait_cyc(4);
        chk("t2_count", 32'(q.size()), 32'(qb + 1));
        chk("t2_out", 32'(q[qb]), 32'h0000FF);

        // Test 3: 10-pixel stream with out_full held for 5 cycles.
        qb = q.size();
        pf = 0;
        fork
            begin
                for (int i = 0; i < 10; i++)
                    push_px(8'(i * 20), 8'(i * 20 + ((i % 3 == 0) ? 60 : 20)), 24'hC00000 | 24'(i));
            end
            begin
                wait_cyc(3);
                out_full = 1'b1;
                pf = pop_n;
                for (int k = 0; k < 5; k++) begin
                    #1;
                    chk("t3_no_push_full", 32'(out_wr_en), 32'd0);
                    wait_cyc(1);
                end
                chk("t3_pops_full", 32'((pop_n - pf) <= 2), 32'd1);
                out_full = 1'b0;
            end
        join
        wait_cyc(4);
        chk("t3_count", 32'(q.size()), 32'(qb + 10));
        for (int i = 0; i < 10; i++)
            chk("t3_order", 32'(q[qb + i]), (i % 3 == 0) ? 32'h0000FF : (32'hC00000 | 32'(i)));

        // Test 4: only the RGB FIFO empty -> nothing popped.
        pb = pop_n;
        bg_dout = 8'd5; fr_dout = 8'd100; hl_dout = 24'h777777;
        bg_empty = 1'b0; fr_empty = 1'b0; hl_empty = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_cyc(1);
            chk("t4_rd_en", 32'({bg_rd_en, fr_rd_en, hl_rd_en}), 32'd0);
        end
        chk("t4_no_pop", 32'(pop_n), 32'(pb));
        qb = q.size();
        push_px(8'd5, 8'd100, 24'h777777);
        wait_cyc(4);
        chk("t4_single_pop", 32'(pop_n), 32'(pb + 1));
        chk("t4_out", 32'(q[qb]), 32'h0000FF);

        // Test 5: two 4x2 frames, 3 then 1 motion pixels.
        reset = 1'b0;
        wait_cyc(1);
        reset = 1'b1;
        wait_cyc(1);
        qb = q.size(); sb = push_n; fb = fd_n;
        for (int i = 0; i < 8; i++) push_px(bg5[i], fr5[i], 24'h005000 | 24'(i));
        wait_cyc(4);
        for (int i = 0; i < 8; i++)
            chk("t5_pixel", 32'(q[qb + i]), mot5[i] ? 32'h0000FF : (32'h005000 | 32'(i)));
        chk("t5_fd_count", 32'(fd_n), 32'(fb + 1));
        chk("t5_fd_index", 32'(fd_idx), 32'(sb + 7));
        chk("t5_motion_count", 32'(motion_count), 32'd3);
        send_mask(4, 8'b0000_0000, 24'h006000);
        wait_cyc(4);
        chk("t5_mid_frame_fd", 32'(fd_n), 32'(fb + 1));
        chk("t5_mid_frame_count", 32'(motion_count), 32'd3);
        send_mask(4, 8'b0000_0010, 24'h006100);
        wait_cyc(4);
        chk("t5_fd2_count", 32'(fd_n), 32'(fb + 2));
        chk("t5_fd2_index", 32'(fd_idx), 32'(sb + 15));
        chk("t5_motion_count2", 32'(motion_count), 32'd1);

        // Test 6: reset mid-frame with both stages full.
        send_mask(3, 8'b0000_0111, 24'h007000);
        wait_cyc(4);
        out_full = 1'b1;
        send_mask(2, 8'b0000_0011, 24'h007100);
        wait_cyc(1);
        sb = push_n; pb = pop_n;
        bg_empty = 1'b0; fr_empty = 1'b0; hl_empty = 1'b0;
        reset = 1'b0;
        #1;
        chk("t6_rd_en_rst", 32'(bg_rd_en), 32'd0);
        out_full = 1'b0;
        #1;
        chk("t6_wr_en_rst", 32'(out_wr_en), 32'd0);
        chk("t6_count_rst", 32'(motion_count), 32'd0);
        wait_cyc(2);
        chk("t6_no_push_rst", 32'(push_n), 32'(sb));
        chk("t6_no_pop_rst", 32'(pop_n), 32'(pb));
        idle();
        reset = 1'b1;
        wait_cyc(1);
        fb = fd_n; sb = push_n;
        send_mask(8, 8'b1000_0001, 24'h008000);
        wait_cyc(4);
        chk("t6_fd_count", 32'(fd_n), 32'(fb + 1));
        chk("t6_fd_index", 32'(fd_idx), 32'(sb + 7));
        chk("t6_motion_count", 32'(motion_count), 32'd2);
        chk("rd_en_together", 32'(split_n), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
